// File: rtl/noc_tg_pkg.sv
// Shared types and constants for the AXI-Stream mesh traffic generator.
// Beat payload layout is {src, seq, beat}.
package noc_tg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        FINISH
    } tg_state_e;

    localparam int SRC_W  = 4;
    localparam int SEQ_W  = 12;
    localparam int BEAT_W = 16;

    localparam logic [3:0]  LFSR_SEED_LO = 4'hA;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    // Low nibble is always 0xA, so the seed can never be all-zero.
    function automatic logic [15:0] lfsr_seed(input int src);
        logic [31:0] s;
        s = src;
        return {s[11:0], LFSR_SEED_LO};
    endfunction

endpackage

// File: rtl/axis_tg_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), stepped on demand.
// Only the two low bits leave the block; they size inter-packet gaps.
module axis_tg_lfsr
    import noc_tg_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h000A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output logic [1:0] rnd
);

    logic [15:0] q;

    // One right-shift step with tap feedback whenever adv is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (adv) begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign rnd = q[1:0];

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator feeding one mesh node input.
// Emits numbered packets with fixed or round-robin destinations.
module axis_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int TDATA_WIDTH      = 32,
    parameter int TDEST_WIDTH      = 4,
    parameter int SRC_ID           = 0,
    parameter int NUM_NODES        = 4,
    parameter int DISABLE_SELFLOOP = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            num_pkts,
    input  logic [4:0]             pkt_len,
    input  logic                   rr_mode,
    input  logic [TDEST_WIDTH-1:0] fixed_dest,
    input  logic                   gap_en,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pkts_sent
);

    localparam logic [SRC_W-1:0] SRC4 = SRC_W'(SRC_ID);

    tg_state_e              state, state_nx;
    logic [15:0]            npkt_q;
    logic [15:0]            sent_q;
    logic [4:0]             len_q;
    logic [4:0]             beat_q;
    logic [SEQ_W-1:0]       seq_q;
    logic                   rr_q;
    logic                   gap_q;
    logic [TDEST_WIDTH-1:0] dest_q;
    logic [1:0]             gap_cnt;
    logic [1:0]             rnd;
    logic                   xfer;
    logic                   last_beat;
    logic                   pkt_done;
    logic                   last_pkt;

    function automatic logic [TDEST_WIDTH-1:0] rr_next(
        input logic [TDEST_WIDTH-1:0] d
    );
        int n;
        n = (int'(d) + 1) % NUM_NODES;
        if (DISABLE_SELFLOOP != 0 && n == SRC_ID) begin
            n = (n + 1) % NUM_NODES;
        end
        return TDEST_WIDTH'(n);
    endfunction

    assign xfer      = (state == SEND) && axis_out_tready;
    assign last_beat = (beat_q == len_q - 5'd1);
    assign pkt_done  = xfer && last_beat;
    assign last_pkt  = (sent_q + 16'd1 == npkt_q);

    axis_tg_lfsr #(
        .SEED(lfsr_seed(SRC_ID))
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .adv  (pkt_done),
        .rnd  (rnd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (num_pkts == 16'd0) ? FINISH : SEND;
                end
            end
            SEND: begin
                if (pkt_done) begin
                    if (last_pkt) begin
                        state_nx = FINISH;
                    end else if (gap_q) begin
                        state_nx = GAP;
                    end else begin
                        state_nx = SEND;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 2'd0) begin
                    state_nx = SEND;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Run configuration and beat/packet counters; only move on a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            npkt_q  <= '0;
            sent_q  <= '0;
            len_q   <= 5'd1;
            beat_q  <= '0;
            seq_q   <= '0;
            rr_q    <= 1'b0;
            gap_q   <= 1'b0;
            dest_q  <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                npkt_q <= num_pkts;
                len_q  <= (pkt_len == 5'd0) ? 5'd1 : pkt_len;
                rr_q   <= rr_mode;
                gap_q  <= gap_en;
                dest_q <= rr_mode ? '0 : fixed_dest;
                sent_q <= '0;
                beat_q <= '0;
                seq_q  <= '0;
            end
            if (xfer) begin
                if (last_beat) begin
                    beat_q  <= '0;
                    sent_q  <= sent_q + 16'd1;
                    seq_q   <= seq_q + 1'b1;
                    gap_cnt <= rnd;
                    if (rr_q) begin
                        dest_q <= rr_next(dest_q);
                    end
                end else begin
                    beat_q <= beat_q + 5'd1;
                end
            end
            if (state == GAP && gap_cnt != 2'd0) begin
                gap_cnt <= gap_cnt - 2'd1;
            end
        end
    end

    // Stream outputs are zeroed whenever no beat is offered.
    always_comb begin
        axis_out_tvalid = (state == SEND);
        axis_out_tlast  = 1'b0;
        axis_out_tdest  = '0;
        axis_out_tdata  = '0;
        if (axis_out_tvalid) begin
            axis_out_tlast = last_beat;
            axis_out_tdest = dest_q;
            axis_out_tdata = TDATA_WIDTH'({SRC4, seq_q, BEAT_W'(beat_q)});
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign pkts_sent = sent_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Scoreboard bench for axis_traffic_gen: directed runs push expected
// beats; a negedge monitor pops and compares on every transfer.
module tb_axis_traffic_gen;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  dest;
        logic        last;
        logic        end_run;
        int          gmin;
        int          gmax;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        start_v [2];
    logic [15:0] num_pkts;
    logic [4:0]  pkt_len;
    logic        rr_mode;
    logic [3:0]  fixed_dest;
    logic        gap_en;
    logic        tready;
    logic        tvalid  [2];
    logic [31:0] tdata   [2];
    logic        tlast   [2];
    logic [3:0]  tdest   [2];
    logic        busy    [2];
    logic        done    [2];
    logic [15:0] sent    [2];

    item_t       exp_q [2][$];
    int          done_cnt [2];
    int          idle [2];
    logic        pstall [2];
    logic [31:0] pdata [2];
    logic [3:0]  pdest [2];
    logic        plast [2];
    logic        tog;
    int          checks;
    int          errors;
    item_t       it;
    logic        exp_done;

    axis_traffic_gen u_dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_v[0]),
        .num_pkts       (num_pkts),
        .pkt_len        (pkt_len),
        .rr_mode        (rr_mode),
        .fixed_dest     (fixed_dest),
        .gap_en         (gap_en),
        .axis_out_tvalid(tvalid[0]),
        .axis_out_tready(tready),
        .axis_out_tdata (tdata[0]),
        .axis_out_tlast (tlast[0]),
        .axis_out_tdest (tdest[0]),
        .busy           (busy[0]),
        .done           (done[0]),
        .pkts_sent      (sent[0])
    );

    axis_traffic_gen #(
        .SRC_ID          (1),
        .DISABLE_SELFLOOP(1)
    ) u_dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_v[1]),
        .num_pkts       (num_pkts),
        .pkt_len        (pkt_len),
        .rr_mode        (rr_mode),
        .fixed_dest     (fixed_dest),
        .gap_en         (gap_en),
        .axis_out_tvalid(tvalid[1]),
        .axis_out_tready(tready),
        .axis_out_tdata (tdata[1]),
        .axis_out_tlast (tlast[1]),
        .axis_out_tdest (tdest[1]),
        .busy           (busy[1]),
        .done           (done[1]),
        .pkts_sent      (sent[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // tready pattern 1010... while tog is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) tready = ~tready;
        end
    end

    // Monitor: compares transfers, stall holds, gaps and done timing.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pstall[d] = 1'b0;
            end else begin
                if (done_cnt[d] > 0) done_cnt[d]--;
                exp_done = (done_cnt[d] == 0);
                if (exp_done || done[d]) begin
                    checks++;
                    if (done[d] !== exp_done || busy[d] !== 1'b1) begin
                        errors++;
                        $display("FAIL done%0d got done=%b busy=%b want done=%b busy=1",
                                 d, done[d], busy[d], exp_done);
                    end
                    if (exp_done) done_cnt[d] = -1;
                end
                if (pstall[d]) begin
                    checks++;
                    if (tvalid[d] !== 1'b1 || tdata[d] !== pdata[d] ||
                        tdest[d] !== pdest[d] || tlast[d] !== plast[d]) begin
                        errors++;
                        $display("FAIL hold%0d got v=%b d=%h t=%h l=%b want v=1 d=%h t=%h l=%b",
                                 d, tvalid[d], tdata[d], tdest[d], tlast[d],
                                 pdata[d], pdest[d], plast[d]);
                    end
                end
                if (tvalid[d] && tready) begin
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        errors++;
                        $display("FAIL beat%0d got unexpected d=%h t=%h want no beat",
                                 d, tdata[d], tdest[d]);
                    end else begin
                        it = exp_q[d].pop_front();
                        if (tdata[d] !== it.data || tdest[d] !== it.dest ||
                            tlast[d] !== it.last) begin
                            errors++;
                            $display("FAIL beat%0d got d=%h t=%h l=%b want d=%h t=%h l=%b",
                                     d, tdata[d], tdest[d], tlast[d],
                                     it.data, it.dest, it.last);
                        end
                        if (it.gmin >= 0) begin
                            checks++;
                            if (idle[d] < it.gmin || idle[d] > it.gmax) begin
                                errors++;
                                $display("FAIL gap%0d got %0d idle want %0d..%0d",
                                         d, idle[d], it.gmin, it.gmax);
                            end
                        end
                        if (it.last) idle[d] = 0;
                        if (it.end_run) done_cnt[d] = 1;
                    end
                end else if (!tvalid[d]) begin
                    idle[d]++;
                end
                pstall[d] = tvalid[d] && !tready;
                pdata[d]  = tdata[d];
                pdest[d]  = tdest[d];
                plast[d]  = tlast[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] data,
                        input logic [3:0] dest, input logic last,
                        input logic er, input int gmin, input int gmax);
        item_t x;
        x.data    = data;
        x.dest    = dest;
        x.last    = last;
        x.end_run = er;
        x.gmin    = gmin;
        x.gmax    = gmax;
        exp_q[d].push_back(x);
    endtask

    task automatic run(input int d, input logic [15:0] n,
                       input logic [4:0] len, input logic rr,
                       input logic [3:0] fd, input logic gp);
        num_pkts   = n;
        pkt_len    = len;
        rr_mode    = rr;
        fixed_dest = fd;
        gap_en     = gp;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy[d] && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (busy[d]) begin
            errors++;
            $display("FAIL timeout%0d got busy=%b want 0", d, busy[d]);
        end
        tick();
    endtask

    initial begin
        logic [3:0] rr1 [4];
        rr1 = '{4'd0, 4'd2, 4'd3, 4'd0};
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        num_pkts   = '0;
        pkt_len    = '0;
        rr_mode    = 1'b0;
        fixed_dest = '0;
        gap_en     = 1'b0;
        tready     = 1'b1;
        tog        = 1'b0;
        for (int d = 0; d < 2; d++) begin
            done_cnt[d] = -1;
            idle[d]     = 0;
            pstall[d]   = 1'b0;
        end
        repeat (3) tick();

        chk("rst_tvalid", 32'(tvalid[0]), 32'd0);
        chk("rst_tlast", 32'(tlast[0]), 32'd0);
        chk("rst_tdata0", tdata[0], 32'd0);
        chk("rst_tdata1", tdata[1], 32'd0);
        chk("rst_tdest", 32'(tdest[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_sent", 32'(sent[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // three 4-beat round-robin packets, back to back
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                push(0, (p << 16) | b, 4'(p), b == 3, p == 2 && b == 3,
                     (b == 0 && p > 0) ? 0 : -1, 0);
            end
        end
        run(0, 16'd3, 5'd4, 1'b1, 4'd0, 1'b0);
        wait_idle(0);
        chk("rr_sent", 32'(sent[0]), 32'd3);

        // self-loop skipping on SRC_ID=1
        for (int k = 0; k < 4; k++) begin
            push(1, 32'h1000_0000 | (k << 16), rr1[k], 1'b1, k == 3,
                 k > 0 ? 0 : -1, 0);
        end
        run(1, 16'd4, 5'd1, 1'b1, 4'd0, 1'b0);
        wait_idle(1);
        chk("skip_sent", 32'(sent[1]), 32'd4);

        // fixed destination under a toggling tready
        push(0, 32'h0000_0000, 4'd1, 1'b0, 1'b0, -1, 0);
        push(0, 32'h0000_0001, 4'd1, 1'b1, 1'b0, -1, 0);
        push(0, 32'h0001_0000, 4'd1, 1'b0, 1'b0, 0, 0);
        push(0, 32'h0001_0001, 4'd1, 1'b1, 1'b1, -1, 0);
        tog = 1'b1;
        run(0, 16'd2, 5'd2, 1'b0, 4'd1, 1'b0);
        wait_idle(0);
        tog    = 1'b0;
        tready = 1'b1;
        chk("stall_sent", 32'(sent[0]), 32'd2);

        // empty run
        done_cnt[0] = 2;
        run(0, 16'd0, 5'd4, 1'b0, 4'd0, 1'b0);
        chk("zero_busy", 32'(busy[0]), 32'd1);
        chk("zero_tvalid", 32'(tvalid[0]), 32'd0);
        tick();
        chk("zero_busy_end", 32'(busy[0]), 32'd0);
        chk("zero_sent", 32'(sent[0]), 32'd0);

        // random gaps between packets, none after the last
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 2; b++) begin
                push(0, (p << 16) | b, 4'd3, b == 1, p == 4 && b == 1,
                     (b == 0 && p > 0) ? 1 : -1, 4);
            end
        end
        run(0, 16'd5, 5'd2, 1'b0, 4'd3, 1'b1);
        wait_idle(0);
        chk("gap_sent", 32'(sent[0]), 32'd5);

        // reset on the third beat abandons the packet
        push(0, 32'h0000_0000, 4'd2, 1'b0, 1'b0, -1, 0);
        push(0, 32'h0000_0001, 4'd2, 1'b0, 1'b0, -1, 0);
        run(0, 16'd1, 5'd4, 1'b0, 4'd2, 1'b0);
        tick();
        tick();
        chk("pre_rst_tdata", tdata[0], 32'h0000_0002);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_tvalid", 32'(tvalid[0]), 32'd0);
        chk("mid_rst_sent", 32'(sent[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy[0]), 32'd0);
        push(0, 32'h0000_0000, 4'd2, 1'b1, 1'b1, -1, 0);
        run(0, 16'd1, 5'd1, 1'b0, 4'd2, 1'b0);
        wait_idle(0);
        chk("post_rst_sent", 32'(sent[0]), 32'd1);
        repeat (3) tick();

        chk("drain0", 32'(exp_q[0].size()), 32'd0);
        chk("drain1", 32'(exp_q[1].size()), 32'd0);
        chk("done_pending0", 32'(done_cnt[0]), 32'hFFFF_FFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_traffic_gen.md
AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32, width of the stream data word (at least 32).
REQ-002 SHALL have parameter TDEST_WIDTH, default 4, width of the destination field.
REQ-003 SHALL have parameter SRC_ID, default 0, mesh node index of this generator.
REQ-004 SHALL have parameter NUM_NODES, default 4, number of valid destinations, 0..NUM_NODES-1.
REQ-005 SHALL have parameter DISABLE_SELFLOOP, default 0; when 1, round-robin mode never targets SRC_ID.
REQ-006 SHALL have port clk, input, 1 bit: the only clock. All logic is synchronous to it.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: single-cycle pulse that launches a run.
REQ-009 SHALL have port num_pkts, input, 16 bits: number of packets in the run, latched on start.
REQ-010 SHALL have port pkt_len, input, 5 bits: beats per packet, latched on start; 0 is treated as 1.
REQ-011 SHALL have port rr_mode, input, 1 bit: 1 selects round-robin destinations, 0 selects fixed_dest; latched on start.
REQ-012 SHALL have port fixed_dest, input, TDEST_WIDTH bits: destination used in fixed mode; latched on start.
REQ-013 SHALL have port gap_en, input, 1 bit: enables pseudo-random idle gaps between packets; latched on start.
REQ-014 SHALL have ports axis_out_tvalid (output, 1), axis_out_tready (input, 1), axis_out_tdata (output, TDATA_WIDTH), axis_out_tlast (output, 1) and axis_out_tdest (output, TDEST_WIDTH). These are the AXI-Stream master driving one mesh node's axis_in port.
REQ-015 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and pkts_sent (output, 16, packets fully accepted in the current run).

Function
REQ-016 SHALL implement the FSM states IDLE, SEND, GAP and FINISH.
REQ-017 In IDLE, start SHALL latch the configuration, clear pkts_sent, beat and sequence counters, and go to SEND. If num_pkts==0, it SHALL go to FINISH instead.
REQ-018 In SEND, tvalid SHALL be 1. A beat is transferred when tvalid&&tready.
REQ-019 Once tvalid is asserted, tdata, tdest and tlast SHALL hold stable until the beat is transferred.
REQ-020 Beat data SHALL be {SRC_ID[3:0], pkt_seq[11:0], beat_idx[15:0]}, zero-extended to TDATA_WIDTH.
REQ-021 tlast SHALL be 1 only on beat index pkt_len-1.
REQ-022 tdest SHALL be constant for all beats of a packet.
REQ-023 In round-robin mode, the first packet SHALL go to dest 0. Each later packet SHALL go to (prev+1) mod NUM_NODES, skipping SRC_ID when DISABLE_SELFLOOP=1.
REQ-024 When the tlast beat transfers, pkts_sent SHALL increment and pkt_seq SHALL increment, wrapping at 4096.
REQ-025 After the tlast beat transfers: if pkts_sent+1==num_pkts, go to FINISH; else if gap_en, go to GAP; else stay in SEND with zero bubble.
REQ-026 GAP SHALL last lfsr[1:0]+1 cycles with tvalid=0, then return to SEND. The LFSR advances one step per packet.
REQ-027 FINISH SHALL last one cycle with done=1, then go to IDLE.
REQ-028 busy SHALL be 1 in SEND, GAP and FINISH.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 A tready stall of any length SHALL NOT drop, duplicate or reorder beats.

Reset
REQ-031 While rst_n==0 at a clk edge: state=IDLE; tvalid=0, tlast=0, tdata=0, tdest=0, busy=0, done=0, pkts_sent=0; LFSR seeded with {SRC_ID,4'hA} (non-zero).
REQ-032 Reset mid-packet SHALL drop tvalid in the next cycle and abandon the packet; no completion beat is emitted.

Structure
REQ-033 Package noc_tg_pkg SHALL hold the state enum, the field widths for SRC, SEQ and BEAT, and the LFSR seed constant.
REQ-034 A 16-bit Galois LFSR SHALL be a separate sub-module axis_tg_lfsr with an advance-enable input.

Verification
REQ-035 num_pkts=3, pkt_len=4, rr_mode=1, NUM_NODES=4, tready=1 -> 12 consecutive beats; tdest 0,1,2; tlast on beats 3, 7 and 11; done pulses 1 cycle after beat 11; pkts_sent=3.
REQ-036 SRC_ID=1, DISABLE_SELFLOOP=1, num_pkts=4, pkt_len=1, rr_mode=1 -> tdest sequence 0,2,3,0.
REQ-037 Fixed dest 4'h1, pkt_len=2, with tready toggling 1010... -> tdata stable through every stall; data 0x0000_0000, 0x0000_0001, then 0x0001_0000, 0x0001_0001.
REQ-038 num_pkts=0 start -> no tvalid; done high exactly one cycle after start; busy high for that one cycle.
REQ-039 gap_en=1, num_pkts=5 -> 1-4 idle cycles between packets with tvalid=0; no gap after the last packet.
REQ-040 rst_n low for 1 cycle on the 3rd beat of a 4-beat packet with tready=1 -> tvalid=0 next cycle; pkts_sent=0; a later start produces pkt_seq 0.
